// File: rtl/fifo_pkg.sv
// fifo_pkg: occupancy type and read-latency constant shared by the FIFO and its readers
package fifo_pkg;
    typedef logic [1:0] count_t;
    localparam int FIFO_RD_LATENCY = 1;
endpackage

// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: FIFO read port plus valid/ready stream seen by the drain engine
interface fifo_stream_reader_if #(parameter int DATA_WIDTH = 8);
    import fifo_pkg::*;
    logic [DATA_WIDTH-1:0] FIFO_R_DATA;
    logic FIFO_EMPTY;
    logic FIFO_REN;
    logic [DATA_WIDTH-1:0] M_DATA;
    logic M_VALID;
    logic M_READY;
    count_t COUNT;
    modport master(input FIFO_R_DATA, FIFO_EMPTY, M_READY, output FIFO_REN, M_DATA, M_VALID, COUNT);
    modport slave(output FIFO_R_DATA, FIFO_EMPTY, M_READY, input FIFO_REN, M_DATA, M_VALID, COUNT);
endinterface

// File: rtl/fifo_stream_buf.sv
// fifo_stream_buf: 2-entry register buffer with head/tail pointers and occupancy count
module fifo_stream_buf import fifo_pkg::*; #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output count_t                count
);
    logic [DATA_WIDTH-1:0] mem [2];
    logic head, tail;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            head   <= 1'b0;
            tail   <= 1'b0;
            count  <= '0;
        end else begin
            if (wr) begin
                mem[tail] <= wr_data;
                tail      <= !tail;
            end
            if (pop) head <= !head;
            count <= count + count_t'(wr) - count_t'(pop);
        end
    end
    assign rd_data = mem[head];
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a FIFO read port into a bubble-free valid/ready stream,
// hiding the FIFO's one-cycle registered read latency.
module fifo_stream_reader import fifo_pkg::*; #(
    parameter int DATA_WIDTH = 8
) (
    input logic                  CLK,
    input logic                  RST_N,
    fifo_stream_reader_if.master bus
);
    logic       inflight;
    logic       pop;
    logic [2:0] occ;
    assign pop          = bus.M_VALID && bus.M_READY;
    // occupancy after this cycle, counting the word already on its way from the FIFO
    assign occ          = 3'(bus.COUNT) + 3'(inflight) - 3'(pop);
    assign bus.FIFO_REN = RST_N && !bus.FIFO_EMPTY && occ < 3'd2;
    assign bus.M_VALID  = bus.COUNT != '0;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) inflight <= 1'b0;
        else        inflight <= bus.FIFO_REN;
    end
    fifo_stream_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk     (CLK),
        .rst_n   (RST_N),
        .wr      (inflight),
        .wr_data (bus.FIFO_R_DATA),
        .pop     (pop),
        .rd_data (bus.M_DATA),
        .count   (bus.COUNT)
    );
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: model FIFO feeding the reader; stimulus queues expected beats,
// a negedge monitor pops and compares every accepted beat and checks stream invariants.
module tb_fifo_stream_reader;
    import fifo_pkg::*;
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    fifo_stream_reader_if #(.DATA_WIDTH(8)) bus ();
    fifo_stream_reader #(.DATA_WIDTH(8)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

    logic [7:0] mem [1024];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic [7:0] r_data = '0;
    logic       ready = 1'b0;
    logic       force_empty = 1'b0;
    logic [7:0] exp_q [$];
    int         tests = 0;
    int         fails = 0;

    assign bus.FIFO_R_DATA = r_data;
    assign bus.FIFO_EMPTY  = (rd_ptr == wr_ptr) || force_empty;
    assign bus.M_READY     = ready;

    // registered-read FIFO model: data appears the cycle after REN
    always @(posedge CLK) begin
        if (bus.FIFO_REN) begin
            r_data <= mem[rd_ptr % 1024];
            rd_ptr <= rd_ptr + 1;
        end
    end

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        mem[wr_ptr % 1024] = v;
        wr_ptr++;
        exp_q.push_back(v);
    endtask

    task automatic drain(input string name, input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    logic       stall = 1'b0;
    logic [7:0] held = '0;
    always @(negedge CLK) begin
        if (RST_N) begin
            check("ren_vs_empty", int'(bus.FIFO_EMPTY && bus.FIFO_REN), 0);
            check("count_max", int'(bus.COUNT > 2'd2), 0);
            if (stall && bus.M_VALID) check("hold_data", int'(bus.M_DATA), int'(held));
            if (bus.M_VALID && bus.M_READY) begin
                if (exp_q.size() == 0) check("extra_beat", exp_q.size(), 1);
                else check("beat_data", int'(bus.M_DATA), int'(exp_q.pop_front()));
            end
            stall = bus.M_VALID && !bus.M_READY;
            held  = bus.M_DATA;
        end else begin
            stall = 1'b0;
        end
    end

    initial begin
        int start;
        int n;
        RST_N = 1'b0;
        ready = 1'b1;
        for (int i = 1; i <= 16; i++) push(8'(i));
        repeat (3) begin
            tick();
            check("rst_ren", int'(bus.FIFO_REN), 0);
            check("rst_valid", int'(bus.M_VALID), 0);
            check("rst_count", int'(bus.COUNT), 0);
            check("rst_data", int'(bus.M_DATA), 0);
        end
        RST_N = 1'b1;
        #1;
        check("first_ren", int'(bus.FIFO_REN), 1);
        check("first_valid", int'(bus.M_VALID), 0);
        tick();
        check("lat1_valid", int'(bus.M_VALID), 0);
        tick();
        for (int i = 0; i < 16; i++) begin
            check("burst_valid", int'(bus.M_VALID), 1);
            tick();
        end
        check("burst_end_valid", int'(bus.M_VALID), 0);
        check("burst_end_ren", int'(bus.FIFO_REN), 0);
        check("burst_end_count", int'(bus.COUNT), 0);
        check("burst_left", exp_q.size(), 0);

        ready = 1'b0;
        start = rd_ptr;
        push(8'h01); push(8'h02); push(8'h03);
        repeat (6) tick();
        check("bp_reads", rd_ptr - start, 2);
        check("bp_count", int'(bus.COUNT), 2);
        check("bp_data", int'(bus.M_DATA), 8'h01);
        check("bp_ren", int'(bus.FIFO_REN), 0);
        ready = 1'b1;
        drain("bp_drain", 20);

        ready = 1'b0;
        push(8'h21); push(8'h22); push(8'h23); push(8'h24);
        repeat (5) tick();
        check("pulse_count", int'(bus.COUNT), 2);
        check("pulse_data", int'(bus.M_DATA), 8'h21);
        ready = 1'b1;
        #1;
        check("pulse_ren", int'(bus.FIFO_REN), 1);
        tick();
        ready = 1'b0;
        #1;
        check("boundary_ren", int'(bus.FIFO_REN), 0);
        check("boundary_count", int'(bus.COUNT), 1);
        check("boundary_data", int'(bus.M_DATA), 8'h22);
        tick();
        check("refill_count", int'(bus.COUNT), 2);
        check("refill_data", int'(bus.M_DATA), 8'h22);
        ready = 1'b1;
        drain("pulse_drain", 20);

        for (int i = 0; i < 10; i++) push(8'(8'h31 + i));
        repeat (4) tick();
        RST_N = 1'b0;
        #1;
        check("midrst_ren", int'(bus.FIFO_REN), 0);
        check("midrst_valid", int'(bus.M_VALID), 0);
        check("midrst_count", int'(bus.COUNT), 0);
        check("midrst_data", int'(bus.M_DATA), 0);
        wr_ptr = rd_ptr;
        exp_q.delete();
        tick();
        RST_N = 1'b1;
        tick();
        check("postrst_valid", int'(bus.M_VALID), 0);

        for (int i = 0; i < 200; i++) push(8'((i * 7 + 3) & 8'hff));
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        ready = 1'b1;
        check("rand_drain", exp_q.size(), 0);

        start = rd_ptr;
        for (int i = 0; i < 20; i++) push(8'(8'h80 + i));
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            force_empty = ~force_empty;
            tick();
            n++;
        end
        force_empty = 1'b0;
        check("toggle_drain", exp_q.size(), 0);
        check("toggle_reads", rd_ptr - start, 20);
        repeat (3) tick();
        check("final_count", int'(bus.COUNT), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
